fetch_sequencer: RTL and testbench

Instruction-fetch controller that sits in front of the instruction FIFO. It owns the fetch PC and issues one 64-bit (two-instruction) I-cache request at a time. It writes the returned words into the FIFO through its dual write port and sequences branch/exception redirects. This includes the FIFO flush strobes and the refetch of a branch delay slot that has not yet been fetched.

---
 rtl/fetch_sequencer_if.sv | 34 +++
 rtl/fetch_sequencer.sv | 132 +++++++++++++
 tb/tb_fetch_sequencer.sv | 283 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Fetch-side bus bundle: instruction FIFO write port plus the I-cache request/response channel.
// The sequencer drives it through the master modport; the FIFO/I-cache side uses slave.
interface fetch_sequencer_if;
  logic        fifo_full;
  logic        fifo_rst;
  logic        fifo_rst_with_delay;
  logic        fifo_write_en1;
  logic        fifo_write_en2;
  logic [31:0] fifo_write_data1;
  logic [31:0] fifo_write_data2;
  logic [31:0] fifo_write_address1;
  logic [31:0] fifo_write_address2;
  logic [2:0]  fifo_write_inst_exp1;
  logic        ic_req;
  logic [31:0] ic_addr;
  logic        ic_addr_ok;
  logic        ic_data_ok;
  logic [63:0] ic_rdata;
  logic        ic_error;

  modport master (
    input  fifo_full, ic_addr_ok, ic_data_ok, ic_rdata, ic_error,
    output fifo_rst, fifo_rst_with_delay, fifo_write_en1, fifo_write_en2,
           fifo_write_data1, fifo_write_data2, fifo_write_address1,
           fifo_write_address2, fifo_write_inst_exp1, ic_req, ic_addr
  );

  modport slave (
    output fifo_full, ic_addr_ok, ic_data_ok, ic_rdata, ic_error,
    input  fifo_rst, fifo_rst_with_delay, fifo_write_en1, fifo_write_en2,
           fifo_write_data1, fifo_write_data2, fifo_write_address1,
           fifo_write_address2, fifo_write_inst_exp1, ic_req, ic_addr
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the fetch PC, keeps one 64-bit I-cache request in flight,
// writes returned words into the instruction FIFO and sequences redirects/delay-slot refetch.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'hBFC0_0000,
  parameter int          EXP_ADEL = 0,
  parameter int          EXP_BUS  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   fetch_stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  input  logic                   redirect_delay,
  input  logic                   redirect_slot_missing,
  fetch_sequencer_if.master      bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HALT} state_t;

  state_t      state_q;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q;
  logic        kill_q;
  logic        slot_q;
  logic        ic_req_q;
  logic [31:0] ic_addr_q;

  logic        deliver;
  logic        wr_live;
  logic        misaligned_wr;
  logic        slot_redir;
  logic        outstanding;

  always_comb begin
    deliver       = !rst && (state_q == WAIT) && bus.ic_data_ok;
    wr_live       = deliver && !kill_q;
    misaligned_wr = !rst && (state_q == IDLE) && (pc_q[1:0] != 2'b00) && !redirect_valid;
    slot_redir    = redirect_valid && redirect_delay && redirect_slot_missing;
    // A request still in flight after this edge must be drained even if redirected.
    outstanding   = (state_q == REQ) || ((state_q == WAIT) && !bus.ic_data_ok);

    pc_d = pc_q;
    if (wr_live && !bus.ic_error)
      pc_d = slot_q ? target_q : (pc_q + (pc_q[2] ? 32'd4 : 32'd8));
  end

  always_comb begin
    bus.fifo_rst             = rst | redirect_valid;
    bus.fifo_rst_with_delay  = redirect_valid & redirect_delay;
    bus.ic_req               = ic_req_q;
    bus.ic_addr              = ic_addr_q;
    bus.fifo_write_en1       = 1'b0;
    bus.fifo_write_en2       = 1'b0;
    bus.fifo_write_data1     = 32'd0;
    bus.fifo_write_data2     = 32'd0;
    bus.fifo_write_address1  = pc_q;
    bus.fifo_write_address2  = pc_q + 32'd4;
    bus.fifo_write_inst_exp1 = 3'b000;
    if (wr_live && bus.ic_error) begin
      bus.fifo_write_en1                = 1'b1;
      bus.fifo_write_inst_exp1[EXP_BUS] = 1'b1;
    end else if (wr_live && (slot_q || pc_q[2])) begin
      bus.fifo_write_en1   = 1'b1;
      bus.fifo_write_data1 = pc_q[2] ? bus.ic_rdata[63:32] : bus.ic_rdata[31:0];
    end else if (wr_live) begin
      bus.fifo_write_en1   = 1'b1;
      bus.fifo_write_en2   = 1'b1;
      bus.fifo_write_data1 = bus.ic_rdata[31:0];
      bus.fifo_write_data2 = bus.ic_rdata[63:32];
    end else if (misaligned_wr) begin
      bus.fifo_write_en1                 = 1'b1;
      bus.fifo_write_inst_exp1[EXP_ADEL] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pc_q      <= RESET_PC;
      target_q  <= 32'd0;
      kill_q    <= 1'b0;
      slot_q    <= 1'b0;
      ic_req_q  <= 1'b0;
      ic_addr_q <= 32'd0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (pc_q[1:0] != 2'b00) begin
            state_q <= HALT;
          end else if (!bus.fifo_full && !fetch_stall) begin
            state_q   <= REQ;
            ic_req_q  <= 1'b1;
            ic_addr_q <= {pc_q[31:3], 3'b000};
          end
        end
        REQ: begin
          if (bus.ic_addr_ok) begin
            state_q  <= WAIT;
            ic_req_q <= 1'b0;
          end
        end
        WAIT: begin
          if (bus.ic_data_ok) begin
            kill_q  <= 1'b0;
            state_q <= (!kill_q && bus.ic_error) ? HALT : IDLE;
            if (!kill_q && !bus.ic_error) slot_q <= 1'b0;
          end
        end
        default: ;
      endcase

      pc_q <= pc_d;

      if (redirect_valid) begin
        if (!outstanding) begin
          state_q  <= IDLE;
          ic_req_q <= 1'b0;
        end
        // With a missing delay slot, pc keeps addressing the slot; the target waits in target_q.
        if (slot_redir) begin
          target_q <= redirect_pc;
          slot_q   <= 1'b1;
        end else begin
          pc_q   <= redirect_pc;
          slot_q <= 1'b0;
          kill_q <= outstanding;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: I-cache responses are hand-driven step by step.
module tb_fetch_sequencer;

  logic        clk;
  logic        rst;
  logic        fetch_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_delay;
  logic        redirect_slot_missing;
  int          checks;
  int          failures;

  fetch_sequencer_if bus ();

  fetch_sequencer #(
    .RESET_PC (32'hBFC0_0000),
    .EXP_ADEL (0),
    .EXP_BUS  (1)
  ) dut (
    .clk                   (clk),
    .rst                   (rst),
    .fetch_stall           (fetch_stall),
    .redirect_valid        (redirect_valid),
    .redirect_pc           (redirect_pc),
    .redirect_delay        (redirect_delay),
    .redirect_slot_missing (redirect_slot_missing),
    .bus                   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    fetch_stall = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'd0;
    redirect_delay = 1'b0;
    redirect_slot_missing = 1'b0;
    bus.fifo_full = 1'b0;
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b0;
    bus.ic_rdata = 64'd0;
    bus.ic_error = 1'b0;

    // Reset
    tick(); tick();
    settle();
    check("rst_fifo_rst", bus.fifo_rst, 1);
    check("rst_ic_req", bus.ic_req, 0);
    check("rst_en1", bus.fifo_write_en1, 0);
    rst = 1'b0;
    settle();
    check("rst_release_fifo_rst", bus.fifo_rst, 0);

    // First fetch from the reset vector
    tick();
    settle();
    check("boot_req", bus.ic_req, 1);
    check("boot_addr", bus.ic_addr, 32'hBFC0_0000);
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b1;
    bus.ic_rdata = 64'h2400_0002_2400_0001;
    settle();
    check("boot_req_drop", bus.ic_req, 0);
    check("boot_en1", bus.fifo_write_en1, 1);
    check("boot_en2", bus.fifo_write_en2, 1);
    check("boot_data1", bus.fifo_write_data1, 32'h2400_0001);
    check("boot_data2", bus.fifo_write_data2, 32'h2400_0002);
    check("boot_addr1", bus.fifo_write_address1, 32'hBFC0_0000);
    check("boot_addr2", bus.fifo_write_address2, 32'hBFC0_0004);
    check("boot_exp", bus.fifo_write_inst_exp1, 3'b000);
    tick();
    bus.ic_data_ok = 1'b0;
    settle();
    check("boot_no_write_after", bus.fifo_write_en1, 0);
    tick();
    settle();
    check("seq_addr", bus.ic_addr, 32'hBFC0_0008);

    // Redirect (no slot) while a request is in flight: its data must be dropped
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0104;
    settle();
    check("redir_fifo_rst", bus.fifo_rst, 1);
    check("redir_rst_delay", bus.fifo_rst_with_delay, 0);
    tick();
    redirect_valid = 1'b0;
    settle();
    check("redir_fifo_rst_pulse", bus.fifo_rst, 0);
    check("killed_req_addr_stable", bus.ic_addr, 32'hBFC0_0008);
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    tick(); tick();
    bus.ic_data_ok = 1'b1;
    bus.ic_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    settle();
    check("killed_no_write", bus.fifo_write_en1, 0);
    tick();
    bus.ic_data_ok = 1'b0;
    tick();
    settle();
    check("redir_target_addr", bus.ic_addr, 32'h8000_0100);
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b1;
    bus.ic_rdata = 64'hAAAA_0002_1111_0001;
    settle();
    check("odd_en1", bus.fifo_write_en1, 1);
    check("odd_en2", bus.fifo_write_en2, 0);
    check("odd_data1", bus.fifo_write_data1, 32'hAAAA_0002);
    check("odd_addr1", bus.fifo_write_address1, 32'h8000_0104);
    tick();
    bus.ic_data_ok = 1'b0;
    tick();
    settle();
    check("odd_next_addr", bus.ic_addr, 32'h8000_0108);

    // Complete that fetch, then park in IDLE with fetch_stall
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b1;
    bus.ic_rdata = 64'h3333_0002_3333_0001;
    fetch_stall = 1'b1;
    settle();
    check("pair_addr2", bus.fifo_write_address2, 32'h8000_010C);
    tick();
    bus.ic_data_ok = 1'b0;
    settle();
    check("stall_no_req", bus.ic_req, 0);
    redirect_valid = 1'b1;
    redirect_pc = 32'hBFC0_0010;
    tick();

    // Redirect with a missing delay slot at pc=BFC0_0010
    redirect_pc = 32'h8000_0000;
    redirect_delay = 1'b1;
    redirect_slot_missing = 1'b1;
    settle();
    check("slot_fifo_rst", bus.fifo_rst, 1);
    check("slot_rst_delay", bus.fifo_rst_with_delay, 1);
    tick();
    redirect_valid = 1'b0;
    redirect_delay = 1'b0;
    redirect_slot_missing = 1'b0;
    fetch_stall = 1'b0;
    settle();
    check("slot_rst_delay_pulse", bus.fifo_rst_with_delay, 0);
    tick();
    settle();
    check("slot_req_addr", bus.ic_addr, 32'hBFC0_0010);
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b1;
    bus.ic_rdata = 64'h2222_2222_1111_1111;
    settle();
    check("slot_en1", bus.fifo_write_en1, 1);
    check("slot_en2", bus.fifo_write_en2, 0);
    check("slot_data1", bus.fifo_write_data1, 32'h1111_1111);
    check("slot_addr1", bus.fifo_write_address1, 32'hBFC0_0010);
    tick();
    bus.ic_data_ok = 1'b0;
    tick();
    settle();
    check("slot_then_target", bus.ic_addr, 32'h8000_0000);

    // fifo_full blocks issue
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b1;
    bus.ic_rdata = 64'h4444_0002_4444_0001;
    bus.fifo_full = 1'b1;
    settle();
    check("target_en2", bus.fifo_write_en2, 1);
    tick();
    bus.ic_data_ok = 1'b0;
    tick(); tick();
    settle();
    check("full_no_req", bus.ic_req, 0);
    bus.fifo_full = 1'b0;
    tick();
    settle();
    check("full_release_req", bus.ic_req, 1);
    check("full_release_addr", bus.ic_addr, 32'h8000_0008);

    // Misaligned redirect target -> address error entry, then HALT
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0002;
    tick();
    redirect_valid = 1'b0;
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b1;
    settle();
    check("mis_killed_no_write", bus.fifo_write_en1, 0);
    tick();
    bus.ic_data_ok = 1'b0;
    settle();
    check("adel_en1", bus.fifo_write_en1, 1);
    check("adel_en2", bus.fifo_write_en2, 0);
    check("adel_exp", bus.fifo_write_inst_exp1, 3'b001);
    check("adel_addr1", bus.fifo_write_address1, 32'h8000_0002);
    check("adel_data1", bus.fifo_write_data1, 32'd0);
    check("adel_no_req", bus.ic_req, 0);
    tick();
    settle();
    check("halt_no_write", bus.fifo_write_en1, 0);
    tick();
    settle();
    check("halt_no_req", bus.ic_req, 0);

    // Leave HALT by redirect, then a bus error halts again
    redirect_valid = 1'b1;
    redirect_pc = 32'h8000_0010;
    tick();
    redirect_valid = 1'b0;
    tick();
    settle();
    check("halt_exit_addr", bus.ic_addr, 32'h8000_0010);
    bus.ic_addr_ok = 1'b1;
    tick();
    bus.ic_addr_ok = 1'b0;
    bus.ic_data_ok = 1'b1;
    bus.ic_error = 1'b1;
    bus.ic_rdata = 64'h5555_5555_5555_5555;
    settle();
    check("buserr_en1", bus.fifo_write_en1, 1);
    check("buserr_en2", bus.fifo_write_en2, 0);
    check("buserr_exp", bus.fifo_write_inst_exp1, 3'b010);
    check("buserr_data1", bus.fifo_write_data1, 32'd0);
    tick();
    bus.ic_data_ok = 1'b0;
    bus.ic_error = 1'b0;
    tick(); tick();
    settle();
    check("buserr_halt_req", bus.ic_req, 0);
    check("buserr_halt_write", bus.fifo_write_en1, 0);

    // Redirect in the same cycle as rst: reset vector wins
    rst = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h1234_5678;
    tick();
    rst = 1'b0;
    redirect_valid = 1'b0;
    tick();
    settle();
    check("rst_wins_addr", bus.ic_addr, 32'hBFC0_0000);
    check("rst_wins_req", bus.ic_req, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
